// File: rtl/rr_grant_sequencer_pkg.sv
// rtl/rr_grant_sequencer_pkg.sv - shared types and sizes for the round-robin grant sequencer
package rr_grant_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } rr_state_t;

endpackage

// File: rtl/rr_grant_sequencer_if.sv
// rtl/rr_grant_sequencer_if.sv - request/grant bus between requesters and the sequencer
interface rr_grant_sequencer_if;
  import rr_grant_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic               done;
  logic               grant_valid;
  logic [IDX_W-1:0]   grant_idx;
  logic               timeout;

  // Requester side drives requests and the release pulse
  modport master (
    output req,
    output done,
    input  grant_valid,
    input  grant_idx,
    input  timeout
  );

  // Sequencer side answers with the registered grant
  modport slave (
    input  req,
    input  done,
    output grant_valid,
    output grant_idx,
    output timeout
  );

endinterface

// File: rtl/rr_grant_sequencer_pick.sv
// rtl/rr_grant_sequencer_pick.sv - rotated priority encoder starting just after last_ptr
module rr_pick
  import rr_grant_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_ptr,
  output logic               any,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;

  // Walk last_ptr+1 .. last_ptr+8 (wrapping); the first set bit wins, so the
  // previous owner is checked last and is only re-picked when it is alone.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = last_ptr + IDX_W'(i);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/rr_grant_sequencer.sv
// rtl/rr_grant_sequencer.sv - round-robin arbiter holding one grant until release or timeout
module rr_grant_sequencer
  import rr_grant_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  rr_grant_sequencer_if.slave bus
);

  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  // With the timeout disabled the counter just parks at all-ones.
  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : '1;

  rr_state_t        state_q, state_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0] last_ptr_q, last_ptr_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             grant_valid_q, grant_valid_d;
  logic             timeout_q, timeout_d;

  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic             rel_done, rel_drop, rel_to;

  rr_pick u_pick (
    .req      (bus.req),
    .last_ptr (last_ptr_q),
    .any      (pick_any),
    .idx      (pick_idx)
  );

  assign rel_done = bus.done;
  assign rel_drop = !bus.req[grant_idx_q];
  assign rel_to   = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

  // Next-state and next-output logic; every output is registered below so
  // req/done never reach the decoder combinationally.
  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    last_ptr_d  = last_ptr_q;
    hold_d      = hold_q;
    timeout_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d     = GRANT;
          grant_idx_d = pick_idx;
          hold_d      = '0;
        end
      end
      GRANT: begin
        if (rel_done || rel_drop || rel_to) begin
          // Always drop to IDLE first so the one-hot bus never jumps owners.
          state_d    = IDLE;
          last_ptr_d = grant_idx_q;
          hold_d     = '0;
          timeout_d  = rel_to && !rel_done && !rel_drop;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    grant_valid_d = (state_d == GRANT);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      grant_idx_q   <= '0;
      last_ptr_q    <= IDX_W'(NUM_REQ - 1);
      hold_q        <= '0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_idx_q   <= grant_idx_d;
      last_ptr_q    <= last_ptr_d;
      hold_q        <= hold_d;
      grant_valid_q <= grant_valid_d;
      timeout_q     <= timeout_d;
    end
  end

  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_idx   = grant_idx_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_rr_grant_sequencer.sv
// tb/tb_rr_grant_sequencer.sv - directed self-checking bench for rr_grant_sequencer
module tb_rr_grant_sequencer;
  import rr_grant_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  rr_grant_sequencer_if bus ();

  rr_grant_sequencer #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.done = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    bus.req  = 8'hFF;
    bus.done = 1'b0;
    step();
    step();
    checks++; if (bus.grant_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.grant_valid); end
    checks++; if (bus.grant_idx !== 3'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", bus.grant_idx); end
    checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", bus.timeout); end
    rst_n = 1'b1;
    step();
    checks++; if (bus.grant_valid !== 1'b1) begin errors++; $display("FAIL reset_first_valid got %b want 1", bus.grant_valid); end
    checks++; if (bus.grant_idx !== 3'd0) begin errors++; $display("FAIL reset_first_idx got %0d want 0", bus.grant_idx); end
  endtask

  task automatic test_rotation();
    logic [2:0] exp_idx;
    for (int k = 0; k < 8; k++) begin
      exp_idx  = 3'(k + 1);
      bus.done = 1'b1;
      step();
      bus.done = 1'b0;
      checks++; if (bus.grant_valid !== 1'b0) begin errors++; $display("FAIL rot_gap%0d valid got %b want 0", k, bus.grant_valid); end
      checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL rot_gap%0d timeout got %b want 0", k, bus.timeout); end
      step();
      checks++; if (bus.grant_valid !== 1'b1) begin errors++; $display("FAIL rot%0d valid got %b want 1", k, bus.grant_valid); end
      checks++; if (bus.grant_idx !== exp_idx) begin errors++; $display("FAIL rot%0d idx got %0d want %0d", k, bus.grant_idx, exp_idx); end
    end
  endtask

  task automatic test_sparse_wrap();
    do_reset();
    bus.req = 8'h04;
    step();
    checks++; if (bus.grant_idx !== 3'd2 || bus.grant_valid !== 1'b1) begin errors++; $display("FAIL sparse_setup got v=%b idx=%0d want v=1 idx=2", bus.grant_valid, bus.grant_idx); end
    bus.req  = 8'b0000_0101;
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    step();
    checks++; if (bus.grant_idx !== 3'd0 || bus.grant_valid !== 1'b1) begin errors++; $display("FAIL sparse_wrap0 got v=%b idx=%0d want v=1 idx=0", bus.grant_valid, bus.grant_idx); end
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    step();
    checks++; if (bus.grant_idx !== 3'd2 || bus.grant_valid !== 1'b1) begin errors++; $display("FAIL sparse_next2 got v=%b idx=%0d want v=1 idx=2", bus.grant_valid, bus.grant_idx); end
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    step();
    checks++; if (bus.grant_idx !== 3'd0 || bus.grant_valid !== 1'b1) begin errors++; $display("FAIL sparse_back0 got v=%b idx=%0d want v=1 idx=0", bus.grant_valid, bus.grant_idx); end
  endtask

  task automatic test_drop();
    do_reset();
    bus.req = 8'h08;
    step();
    checks++; if (bus.grant_idx !== 3'd3 || bus.grant_valid !== 1'b1) begin errors++; $display("FAIL drop_setup got v=%b idx=%0d want v=1 idx=3", bus.grant_valid, bus.grant_idx); end
    bus.req = 8'b0001_0001;
    step();
    checks++; if (bus.grant_valid !== 1'b0) begin errors++; $display("FAIL drop_valid got %b want 0", bus.grant_valid); end
    checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL drop_timeout got %b want 0", bus.timeout); end
    checks++; if (bus.grant_idx !== 3'd3) begin errors++; $display("FAIL drop_idx_kept got %0d want 3", bus.grant_idx); end
    step();
    checks++; if (bus.grant_idx !== 3'd4 || bus.grant_valid !== 1'b1) begin errors++; $display("FAIL drop_next got v=%b idx=%0d want v=1 idx=4", bus.grant_valid, bus.grant_idx); end
  endtask

  task automatic test_timeout();
    do_reset();
    bus.req = 8'h10;
    step();
    checks++; if (bus.grant_idx !== 3'd4 || bus.grant_valid !== 1'b1) begin errors++; $display("FAIL to_setup got v=%b idx=%0d want v=1 idx=4", bus.grant_valid, bus.grant_idx); end
    for (int i = 1; i < 4; i++) begin
      step();
      checks++; if (bus.grant_valid !== 1'b1 || bus.timeout !== 1'b0) begin errors++; $display("FAIL to_hold%0d got v=%b to=%b want v=1 to=0", i, bus.grant_valid, bus.timeout); end
    end
    step();
    checks++; if (bus.grant_valid !== 1'b0 || bus.timeout !== 1'b1) begin errors++; $display("FAIL to_pulse got v=%b to=%b want v=0 to=1", bus.grant_valid, bus.timeout); end
    step();
    checks++; if (bus.grant_valid !== 1'b1 || bus.timeout !== 1'b0 || bus.grant_idx !== 3'd4) begin errors++; $display("FAIL to_regrant got v=%b to=%b idx=%0d want v=1 to=0 idx=4", bus.grant_valid, bus.timeout, bus.grant_idx); end
    step();
    step();
    step();
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    checks++; if (bus.grant_valid !== 1'b0 || bus.timeout !== 1'b0) begin errors++; $display("FAIL to_done_coincide got v=%b to=%b want v=0 to=0", bus.grant_valid, bus.timeout); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    bus.req = 8'h20;
    step();
    checks++; if (bus.grant_idx !== 3'd5 || bus.grant_valid !== 1'b1) begin errors++; $display("FAIL mr_setup got v=%b idx=%0d want v=1 idx=5", bus.grant_valid, bus.grant_idx); end
    bus.req = 8'h21;
    rst_n   = 1'b0;
    step();
    rst_n = 1'b1;
    checks++; if (bus.grant_valid !== 1'b0 || bus.grant_idx !== 3'd0 || bus.timeout !== 1'b0) begin errors++; $display("FAIL mr_drop got v=%b idx=%0d to=%b want v=0 idx=0 to=0", bus.grant_valid, bus.grant_idx, bus.timeout); end
    step();
    checks++; if (bus.grant_idx !== 3'd0 || bus.grant_valid !== 1'b1) begin errors++; $display("FAIL mr_first got v=%b idx=%0d want v=1 idx=0", bus.grant_valid, bus.grant_idx); end
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    step();
    checks++; if (bus.grant_idx !== 3'd5 || bus.grant_valid !== 1'b1) begin errors++; $display("FAIL mr_second got v=%b idx=%0d want v=1 idx=5", bus.grant_valid, bus.grant_idx); end
  endtask

  task automatic test_idle_done();
    do_reset();
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    checks++; if (bus.grant_valid !== 1'b0 || bus.timeout !== 1'b0) begin errors++; $display("FAIL idle_done got v=%b to=%b want v=0 to=0", bus.grant_valid, bus.timeout); end
    bus.req = 8'h02;
    step();
    checks++; if (bus.grant_idx !== 3'd1 || bus.grant_valid !== 1'b1) begin errors++; $display("FAIL idle_then_grant got v=%b idx=%0d want v=1 idx=1", bus.grant_valid, bus.grant_idx); end
  endtask

  initial begin
    clk      = 1'b0;
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.done = 1'b0;
    checks   = 0;
    errors   = 0;
    test_reset();
    test_rotation();
    test_sparse_wrap();
    test_drop();
    test_timeout();
    test_mid_reset();
    test_idle_done();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
